// File: rtl/gpio_pkg.sv
// Shared types and constants for the GPIO port controller.
package gpio_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    TURN   = 2'd2,
    DONE   = 2'd3
  } gpio_state_t;

  localparam logic [1:0] ADDR_DOUT = 2'd0;
  localparam logic [1:0] ADDR_DIR  = 2'd1;
  localparam logic [1:0] ADDR_PIN  = 2'd2;
  localparam logic [1:0] ADDR_IRQ  = 2'd3;

  localparam int TURN_W = 4;

endpackage

// File: rtl/gpio_port_ctrl_if.sv
// Request/acknowledge register bus between the core and the GPIO port controller.
interface gpio_port_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             REQ;
  logic             WE;
  logic [1:0]       ADDR;
  logic [WIDTH-1:0] WDATA;
  logic [WIDTH-1:0] RDATA;
  logic             ACK;
  logic             BUSY;

  modport master (
    output REQ, WE, ADDR, WDATA,
    input  RDATA, ACK, BUSY
  );

  modport slave (
    input  REQ, WE, ADDR, WDATA,
    output RDATA, ACK, BUSY
  );
endinterface

// File: rtl/gpio_sync2.sv
// Two-flop synchroniser for asynchronous pin levels, synchronous active-high reset.
module gpio_sync2 #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;

  always_ff @(posedge CLK) begin
    if (RST) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/gpio_port_ctrl.sv
// GPIO port controller: DOUT/DIR registers, bus handshake FSM, input-to-output turnaround.
// Optional pin-change interrupt status enabled by defining GPIO_PORT_IRQ_EN.
module gpio_port_ctrl
  import gpio_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int TURN_CYC = 2
) (
  input  logic             CLK,
  input  logic             RST,
  gpio_port_ctrl_if.slave  bus,
  input  logic [WIDTH-1:0] PIN_IN,
  output logic [WIDTH-1:0] PIN_OUT,
  output logic [WIDTH-1:0] PIN_OE
`ifdef GPIO_PORT_IRQ_EN
  ,
  output logic             IRQ
`endif
);

  localparam bit HAS_TURN = (TURN_CYC > 0);
  localparam int TURN_LOAD_I = (TURN_CYC > 0) ? TURN_CYC - 1 : 0;
  localparam logic [TURN_W-1:0] TURN_LOAD = TURN_LOAD_I[TURN_W-1:0];

  gpio_state_t state, state_nx;

  logic             we_q;
  logic [1:0]       addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] dir_prev;
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] pin_s2;
  logic [WIDTH-1:0] status_rd;
  logic [WIDTH-1:0] read_val;
  logic [TURN_W-1:0] turn_cnt;
  logic             dir_rising;

  gpio_sync2 #(.WIDTH(WIDTH)) u_sync (
    .CLK (CLK),
    .RST (RST),
    .d   (PIN_IN),
    .q   (pin_s2)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  // A DIR write that turns any pin into an output must wait out the turnaround.
  assign dir_rising = we_q && (addr_q == ADDR_DIR) && (|(~dir & wdata_q));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.REQ) state_nx = ACCESS;
      ACCESS:  state_nx = (dir_rising && HAS_TURN) ? TURN : DONE;
      TURN:    if (turn_cnt == '0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.ACK   = (state == DONE);
    bus.BUSY  = (state != IDLE);
    bus.RDATA = (state == DONE) ? rdata_q : '0;
    PIN_OUT   = dout;
    PIN_OE    = (state == TURN) ? (dir_prev & dir) : dir;
  end

  always_comb begin
    read_val = '0;
    case (addr_q)
      ADDR_DOUT: read_val = dout;
      ADDR_DIR:  read_val = dir;
      ADDR_PIN:  read_val = pin_s2;
      ADDR_IRQ:  read_val = status_rd;
      default:   read_val = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      dout     <= '0;
      dir      <= '0;
      dir_prev <= '0;
      rdata_q  <= '0;
      turn_cnt <= '0;
    end else begin
      if (state == IDLE && bus.REQ) begin
        we_q    <= bus.WE;
        addr_q  <= bus.ADDR;
        wdata_q <= bus.WDATA;
      end
      if (state == ACCESS) begin
        dir_prev <= dir;
        if (we_q) begin
          if (addr_q == ADDR_DOUT) dout <= wdata_q;
          if (addr_q == ADDR_DIR)  dir  <= wdata_q;
        end else begin
          rdata_q <= read_val;
        end
      end
      if (state == ACCESS && state_nx == TURN)
        turn_cnt <= TURN_LOAD;
      else if (state == TURN && turn_cnt != '0)
        turn_cnt <= turn_cnt - 1'b1;
    end
  end

`ifdef GPIO_PORT_IRQ_EN
  logic [WIDTH-1:0] pin_s3;
  logic [WIDTH-1:0] status;
  logic [WIDTH-1:0] irq_set;
  logic [WIDTH-1:0] irq_clr;
  logic             irq_q;

  // Only input pins can raise a change event; a fresh edge beats a same-cycle clear.
  always_comb begin
    irq_set = (pin_s2 ^ pin_s3) & ~dir;
    irq_clr = (state == ACCESS && we_q && addr_q == ADDR_IRQ) ? wdata_q : '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pin_s3 <= '0;
      status <= '0;
      irq_q  <= 1'b0;
    end else begin
      pin_s3 <= pin_s2;
      status <= (status & ~irq_clr) | irq_set;
      irq_q  <= |status;
    end
  end

  assign status_rd = status;
  assign IRQ       = irq_q;
`else
  assign status_rd = '0;
`endif

endmodule

// File: tb/tb_gpio_port_ctrl.sv
// Scoreboard testbench for gpio_port_ctrl: expectations queued at request, checked at ACK.
module tb_gpio_port_ctrl;

  localparam int WIDTH    = 8;
  localparam int TURN_CYC = 2;

  typedef struct {
    logic       isRead;
    logic [7:0] rdata;
    int         cycles;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] PIN_IN;
  logic [7:0] PIN_OUT;
  logic [7:0] PIN_OE;
`ifdef GPIO_PORT_IRQ_EN
  logic       IRQ;
`endif

  gpio_port_ctrl_if #(.WIDTH(WIDTH)) bus ();

  gpio_port_ctrl #(
    .WIDTH    (WIDTH),
    .TURN_CYC (TURN_CYC)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .bus     (bus),
    .PIN_IN  (PIN_IN),
    .PIN_OUT (PIN_OUT),
    .PIN_OE  (PIN_OE)
`ifdef GPIO_PORT_IRQ_EN
    ,
    .IRQ     (IRQ)
`endif
  );

  always #5 CLK = ~CLK;

  exp_t       expQ[$];
  int         checkCount = 0;
  int         passCount  = 0;
  int         busyRun    = 0;
  logic [7:0] oeSeen [0:15];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // Tracks how long the current transaction has been busy and scores each ACK.
  always @(negedge CLK) begin : monitor
    exp_t e;
    if (bus.BUSY === 1'b1) busyRun = busyRun + 1;
    else busyRun = 0;
    if (busyRun > 0 && busyRun < 16) oeSeen[busyRun] = PIN_OE;
    if (bus.ACK === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("sb_unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = expQ.pop_front();
        if (e.isRead) checkOutput("rdata", {24'd0, bus.RDATA}, {24'd0, e.rdata});
        checkOutput("latency", busyRun, e.cycles);
      end
    end
  end

  task automatic applyStimulus(input logic we, input logic [1:0] addr, input logic [7:0] wdata,
                               input logic [7:0] pinIn, input logic [7:0] expRdata, input int expCycles);
    exp_t e;
    int   waited;
    logic gotAck;
    e.isRead = !we;
    e.rdata  = expRdata;
    e.cycles = expCycles;
    expQ.push_back(e);
    @(posedge CLK);
    #1;
    PIN_IN    = pinIn;
    bus.REQ   = 1'b1;
    bus.WE    = we;
    bus.ADDR  = addr;
    bus.WDATA = wdata;
    gotAck = 1'b0;
    waited = 0;
    while (!gotAck && waited < 50) begin
      @(negedge CLK);
      waited++;
      if (bus.ACK === 1'b1) gotAck = 1'b1;
    end
    if (!gotAck) begin
      checkOutput("ack_timeout", 32'd0, 32'd1);
      if (expQ.size() > 0) e = expQ.pop_front();
    end
    @(posedge CLK);
    #1;
    bus.REQ = 1'b0;
    bus.WE  = 1'b0;
    checkOutput("idle_after_ack", {22'd0, bus.BUSY, bus.ACK, bus.RDATA}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
`ifdef GPIO_PORT_IRQ_EN
    logic irqSeen;
`endif
    RST       = 1'b1;
    bus.REQ   = 1'b0;
    bus.WE    = 1'b0;
    bus.ADDR  = 2'd0;
    bus.WDATA = 8'h00;
    PIN_IN    = 8'h00;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkOutput("rst_busy",    {31'd0, bus.BUSY}, 32'd0);
    checkOutput("rst_ack",     {31'd0, bus.ACK},  32'd0);
    checkOutput("rst_rdata",   {24'd0, bus.RDATA}, 32'd0);
    checkOutput("rst_pin_out", {24'd0, PIN_OUT},  32'd0);
    checkOutput("rst_pin_oe",  {24'd0, PIN_OE},   32'd0);
    @(posedge CLK);
    #1 RST = 1'b0;

    applyStimulus(1'b1, 2'd0, 8'hA5, 8'h00, 8'h00, 2);
    checkOutput("dout_pin_out", {24'd0, PIN_OUT}, 32'hA5);
    checkOutput("dout_pin_oe",  {24'd0, PIN_OE},  32'h00);
    applyStimulus(1'b0, 2'd0, 8'h00, 8'h00, 8'hA5, 2);

    applyStimulus(1'b1, 2'd1, 8'h0F, 8'h00, 8'h00, 2 + TURN_CYC);
    checkOutput("turn_oe_access", {24'd0, oeSeen[1]}, 32'h00);
    checkOutput("turn_oe_turn1",  {24'd0, oeSeen[2]}, 32'h00);
    checkOutput("turn_oe_turn2",  {24'd0, oeSeen[3]}, 32'h00);
    checkOutput("turn_oe_done",   {24'd0, oeSeen[4]}, 32'h0F);

    applyStimulus(1'b1, 2'd1, 8'h03, 8'h00, 8'h00, 2);
    checkOutput("fall_oe_access", {24'd0, oeSeen[1]}, 32'h0F);
    checkOutput("fall_oe_done",   {24'd0, oeSeen[2]}, 32'h03);
    applyStimulus(1'b0, 2'd1, 8'h00, 8'h00, 8'h03, 2);

    @(posedge CLK);
    #1 PIN_IN = 8'h3C;
    repeat (3) @(posedge CLK);
    applyStimulus(1'b0, 2'd2, 8'h00, 8'h3C, 8'h3C, 2);
    applyStimulus(1'b0, 2'd2, 8'h00, 8'hC3, 8'h3C, 2);
    applyStimulus(1'b0, 2'd2, 8'h00, 8'hC3, 8'hC3, 2);

    applyStimulus(1'b1, 2'd2, 8'hFF, 8'hC3, 8'h00, 2);
    applyStimulus(1'b0, 2'd0, 8'h00, 8'hC3, 8'hA5, 2);
    applyStimulus(1'b0, 2'd1, 8'h00, 8'hC3, 8'h03, 2);

`ifndef GPIO_PORT_IRQ_EN
    applyStimulus(1'b0, 2'd3, 8'h00, 8'hC3, 8'h00, 2);
    applyStimulus(1'b1, 2'd3, 8'hFF, 8'hC3, 8'h00, 2);
    applyStimulus(1'b0, 2'd3, 8'h00, 8'hC3, 8'h00, 2);
`endif

    // Abort a turnaround with reset; no ACK is expected for this request.
    @(posedge CLK);
    #1;
    bus.REQ   = 1'b1;
    bus.WE    = 1'b1;
    bus.ADDR  = 2'd1;
    bus.WDATA = 8'hF3;
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    checkOutput("midturn_busy", {31'd0, bus.BUSY}, 32'd1);
    checkOutput("midturn_oe",   {24'd0, PIN_OE},   32'h03);
    RST     = 1'b1;
    bus.REQ = 1'b0;
    bus.WE  = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    checkOutput("midrst_busy",    {31'd0, bus.BUSY}, 32'd0);
    checkOutput("midrst_ack",     {31'd0, bus.ACK},  32'd0);
    checkOutput("midrst_pin_oe",  {24'd0, PIN_OE},   32'h00);
    checkOutput("midrst_pin_out", {24'd0, PIN_OUT},  32'h00);
    @(posedge CLK);
    #1 RST = 1'b0;
    applyStimulus(1'b0, 2'd1, 8'h00, 8'hC3, 8'h00, 2);
    applyStimulus(1'b0, 2'd0, 8'h00, 8'hC3, 8'h00, 2);

`ifdef GPIO_PORT_IRQ_EN
    applyStimulus(1'b1, 2'd3, 8'hFF, 8'hC3, 8'h00, 2);
    @(posedge CLK);
    #1;
    checkOutput("irq_cleared", {31'd0, IRQ}, 32'd0);
    PIN_IN  = 8'hD3;
    irqSeen = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      if (IRQ === 1'b1) irqSeen = 1'b1;
    end
    checkOutput("irq_rise", {31'd0, irqSeen}, 32'd1);
    applyStimulus(1'b0, 2'd3, 8'h00, 8'hD3, 8'h10, 2);
    applyStimulus(1'b1, 2'd3, 8'h10, 8'hD3, 8'h00, 2);
    checkOutput("irq_w1c", {31'd0, IRQ}, 32'd0);
    PIN_IN = 8'hC3;
    applyStimulus(1'b1, 2'd3, 8'h10, 8'hC3, 8'h00, 2);
    applyStimulus(1'b0, 2'd3, 8'h00, 8'hC3, 8'h10, 2);
    checkOutput("irq_set_wins", {31'd0, IRQ}, 32'd1);
`endif

    checkOutput("sb_drain", expQ.size(), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
